// File: rtl/uart_tx_stream.sv
// UART transmitter fed by a circular FIFO.
// Frames: start, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_stream #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int CLK_FREQ_HZ = 125000000,
  parameter int BAUDRATE    = 9600,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = CLK_FREQ_HZ / BAUDRATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_WIDTH);
  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic PAR = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  ready_en;
  state_t                state;
  logic [CW-1:0]         baud_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  parity;
  logic [DATA_WIDTH-1:0] head;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  baud_done;
  logic                  stop_done;
  logic                  data_done;

  assign fifo_level = level;
  assign fifo_empty = (level == '0);
  assign s_ready    = ready_en && (level != LW'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign head       = mem[rd_ptr];
  assign baud_done  = (baud_cnt == CW'(DIV - 1));
  assign stop_done  = (bit_cnt == BW'(STOP_BITS - 1));
  assign data_done  = (bit_cnt == BW'(DATA_WIDTH - 1));
  // The FSM takes a word when idle, or at the very end of the last
  // stop bit so the next start bit follows with no gap.
  assign pop = !fifo_empty &&
               ((state == IDLE) ||
                (state == STOP && baud_done && stop_done));

  // Storage array: written at the tail on every accepted word.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Pointers and occupancy; ready_en holds s_ready low until the
  // first edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Frame sequencer; every bit lasts DIV cycles of baud_cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (pop) begin
            shift   <= head;
            parity  <= (^head) ^ ODD;
            state   <= START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift[0];
            shift    <= shift >> 1;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (data_done) begin
              bit_cnt <= '0;
              if (PAR) begin
                tx    <= parity;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (stop_done) begin
              frame_done <= 1'b1;
              if (pop) begin
                shift  <= head;
                parity <= (^head) ^ ODD;
                tx     <= 1'b0;
                state  <= START;
              end else begin
                tx      <= 1'b1;
                tx_busy <= 1'b0;
                state   <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench for uart_tx_stream: three instances cover
// no parity / even parity + 2 stops / odd parity at DIV=4.
module tb_uart_tx_stream;

  localparam int DIV = 4;

  typedef struct {
    logic [11:0] bits;
    int          n;
  } frame_t;

  logic       clk;
  logic       rst;
  logic [2:0] valid_v;
  logic [7:0] s_data;
  logic [2:0] ready_v;
  logic [2:0] tx_v;
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [2:0] lvl_v [3];

  int checks = 0;
  int errors = 0;

  frame_t exp_q [3][$];

  uart_tx_stream #(
    .DATA_WIDTH(8), .FIFO_DEPTH(4), .CLK_FREQ_HZ(40), .BAUDRATE(10),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .rst(rst), .s_valid(valid_v[0]), .s_ready(ready_v[0]),
    .s_data(s_data), .tx(tx_v[0]), .tx_busy(busy_v[0]),
    .frame_done(done_v[0]), .fifo_level(lvl_v[0])
  );

  uart_tx_stream #(
    .DATA_WIDTH(8), .FIFO_DEPTH(4), .CLK_FREQ_HZ(40), .BAUDRATE(10),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
  ) dut1 (
    .clk(clk), .rst(rst), .s_valid(valid_v[1]), .s_ready(ready_v[1]),
    .s_data(s_data), .tx(tx_v[1]), .tx_busy(busy_v[1]),
    .frame_done(done_v[1]), .fifo_level(lvl_v[1])
  );

  uart_tx_stream #(
    .DATA_WIDTH(8), .FIFO_DEPTH(4), .CLK_FREQ_HZ(40), .BAUDRATE(10),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
  ) dut2 (
    .clk(clk), .rst(rst), .s_valid(valid_v[2]), .s_ready(ready_v[2]),
    .s_data(s_data), .tx(tx_v[2]), .tx_busy(busy_v[2]),
    .frame_done(done_v[2]), .fifo_level(lvl_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic frame_t mk(input logic [11:0] b, input int n);
    frame_t f;
    f.bits = b;
    f.n    = n;
    return f;
  endfunction

  // 8N1 frame: start 0, data LSB first, stop 1
  function automatic frame_t f8n1(input logic [7:0] d);
    return mk({3'b001, d, 1'b0}, 10);
  endfunction

  // Drive one word; the expected frame enters the scoreboard on acceptance.
  task automatic push(input int id, input logic [7:0] d,
                      input frame_t f, input bit hold);
    int w = 0;
    @(negedge clk);
    valid_v[id] = 1'b1;
    s_data      = d;
    while (!ready_v[id] && w < 400) begin
      chk($sformatf("dut%0d level when blocked", id), int'(lvl_v[id]), 4);
      @(negedge clk);
      w++;
    end
    if (!ready_v[id]) begin
      chk($sformatf("dut%0d push timeout", id), 1, 0);
      valid_v[id] = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q[id].push_back(f);
    #1;
    if (!hold) valid_v[id] = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    int w = 0;
    @(negedge clk);
    while ((exp_q[id].size() != 0 || busy_v[id]) && w < 600) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("dut%0d drain timeout", id), int'(w >= 600), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: on each tx fall, pop the scoreboard and check every cycle.
  task automatic monitor(input int id);
    frame_t f;
    bit more;
    bit abort;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (tx_v[id] !== 1'b0) begin
        chk($sformatf("dut%0d frame_done idle", id), int'(done_v[id]), 0);
        continue;
      end
      more = 1'b1;
      while (more) begin
        more  = 1'b0;
        abort = 1'b0;
        if (exp_q[id].size() == 0) begin
          chk($sformatf("dut%0d unexpected frame", id), 1, 0);
          break;
        end
        f = exp_q[id].pop_front();
        for (int c = 0; c < f.n * DIV; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            exp_q[id].delete();
            break;
          end
          chk($sformatf("dut%0d tx bit %0d cyc %0d", id, c / DIV, c),
              int'(tx_v[id]), int'(f.bits[c / DIV]));
          chk($sformatf("dut%0d busy in frame", id), int'(busy_v[id]), 1);
          if (c > 0) begin
            chk($sformatf("dut%0d frame_done early", id),
                int'(done_v[id]), 0);
          end
        end
        if (!abort) begin
          @(negedge clk);
          if (!rst) begin
            chk($sformatf("dut%0d frame_done end", id), int'(done_v[id]), 1);
            if (exp_q[id].size() != 0) begin
              chk($sformatf("dut%0d gap before next", id), int'(tx_v[id]), 0);
              more = 1'b1;
            end else begin
              chk($sformatf("dut%0d tx idle after", id), int'(tx_v[id]), 1);
              chk($sformatf("dut%0d busy after", id), int'(busy_v[id]), 0);
            end
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  logic [7:0] fill [6];

  initial begin
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h3C;
    fill[3] = 8'h5A; fill[4] = 8'h96; fill[5] = 8'hF0;
    rst     = 1'b1;
    valid_v = 3'b000;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst dut%0d tx", i), int'(tx_v[i]), 1);
      chk($sformatf("rst dut%0d busy", i), int'(busy_v[i]), 0);
      chk($sformatf("rst dut%0d done", i), int'(done_v[i]), 0);
      chk($sformatf("rst dut%0d level", i), int'(lvl_v[i]), 0);
      chk($sformatf("rst dut%0d ready", i), int'(ready_v[i]), 0);
    end
    #1 rst = 1'b0;
    chk("ready before first edge", int'(ready_v[0]), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ready after release dut%0d", i), int'(ready_v[i]), 1);
    end

    // 0xA5 8N1: 0,1,0,1,0,0,1,0,1,1
    push(0, 8'hA5, mk(12'h34A, 10), 1'b0);
    @(posedge clk);
    #1;
    chk("latency tx low", int'(tx_v[0]), 0);
    chk("latency busy", int'(busy_v[0]), 1);
    chk("latency level", int'(lvl_v[0]), 0);
    wait_idle(0);

    // 0x07 even parity, 2 stops: parity 1, 48 cycles
    push(1, 8'h07, mk(12'hE0E, 12), 1'b0);
    wait_idle(1);

    // odd parity: 0x03 -> parity 1, 0x01 -> parity 0
    push(2, 8'h03, mk(12'h606, 11), 1'b0);
    push(2, 8'h01, mk(12'h402, 11), 1'b0);
    wait_idle(2);

    // Fill: six words with s_valid held high
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        @(negedge clk);
        chk("fill ready low", int'(ready_v[0]), 0);
        chk("fill level full", int'(lvl_v[0]), 4);
      end
      push(0, fill[i], f8n1(fill[i]), i < 5);
    end
    wait_idle(0);

    // Same-edge push/pop at level 2
    push(0, 8'h81, f8n1(8'h81), 1'b0);
    @(posedge clk);
    #1;
    chk("se first tx low", int'(tx_v[0]), 0);
    push(0, 8'h42, f8n1(8'h42), 1'b0);
    push(0, 8'h24, f8n1(8'h24), 1'b0);
    repeat (38) @(negedge clk);
    chk("se level before", int'(lvl_v[0]), 2);
    chk("se busy before", int'(busy_v[0]), 1);
    valid_v[0] = 1'b1;
    s_data     = 8'hC3;
    @(posedge clk);
    exp_q[0].push_back(f8n1(8'hC3));
    #1;
    valid_v[0] = 1'b0;
    chk("se level after", int'(lvl_v[0]), 2);
    chk("se next start", int'(tx_v[0]), 0);
    wait_idle(0);

    // Mid-frame reset during data bit 3 with two words queued
    push(0, 8'h00, f8n1(8'h00), 1'b0);
    push(0, 8'h55, f8n1(8'h55), 1'b0);
    push(0, 8'hAA, f8n1(8'hAA), 1'b0);
    repeat (17) @(negedge clk);
    chk("mid level queued", int'(lvl_v[0]), 2);
    chk("mid tx data bit3", int'(tx_v[0]), 0);
    #2 rst = 1'b1;
    #1;
    chk("mid rst tx", int'(tx_v[0]), 1);
    chk("mid rst level", int'(lvl_v[0]), 0);
    chk("mid rst busy", int'(busy_v[0]), 0);
    chk("mid rst ready", int'(ready_v[0]), 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    exp_q[0].delete();
    chk("mid ready before edge", int'(ready_v[0]), 0);
    @(posedge clk);
    #1;
    chk("mid ready after edge", int'(ready_v[0]), 1);
    repeat (100) @(negedge clk);
    chk("mid no frames tx", int'(tx_v[0]), 1);
    chk("mid no frames busy", int'(busy_v[0]), 0);
    chk("mid level stays 0", int'(lvl_v[0]), 0);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d scoreboard empty", i), exp_q[i].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data bits per frame, legal 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: number of FIFO entries, power of two, minimum 2.
REQ-003 SHALL have parameter CLK_FREQ_HZ, default 125000000: clock frequency.
REQ-004 SHALL have parameter BAUDRATE, default 9600: bit rate; DIV = CLK_FREQ_HZ/BAUDRATE (integer truncation), DIV >= 2.
REQ-005 SHALL have parameter PARITY_EN, default 0: 1 = insert a parity bit.
REQ-006 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-007 SHALL have parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-008 SHALL have ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- s_valid  input  1  write request.
- s_ready  output  1  FIFO can accept a word.
- s_data  input  DATA_WIDTH  word to transmit.
- tx  output  1  serial line, idles high.
- tx_busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse at end of the last stop bit.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  count of words held.

Function
REQ-009 SHALL accept a word on a clk rising edge where s_valid=1 and s_ready=1, and only then.
REQ-010 SHALL drive s_ready = (fifo_level != FIFO_DEPTH), combinationally from registered state.
REQ-011 SHALL keep s_data sampled at acceptance; s_data changes while s_ready=0 SHALL have no effect.
REQ-012 SHALL use a circular FIFO with wrap-around read/write pointers; writes SHALL go to the tail and pops SHALL come from the head, preserving order.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE -> START when the FIFO is non-empty; on that edge the FSM SHALL pop the head word into a shift register and set tx_busy=1.
REQ-015 Each START, DATA, PARITY and STOP bit SHALL hold tx for exactly DIV cycles, timed by a baud counter that is cleared on every state or bit change.
REQ-016 START SHALL drive tx=0; afterwards the state SHALL go to DATA.
REQ-017 DATA SHALL shift out DATA_WIDTH bits LSB first; afterwards the state SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-018 The PARITY bit SHALL equal XOR(data) XOR PARITY_ODD.
REQ-019 STOP SHALL drive tx=1 for STOP_BITS*DIV cycles, then pulse frame_done for one cycle.
REQ-020 After STOP, the FSM SHALL go to START directly, popping the next word, if the FIFO is non-empty; otherwise it SHALL go to IDLE with tx_busy=0.
REQ-021 Back-to-back frames SHALL have zero idle cycles between them.
REQ-022 Latency: a word accepted at edge k into an empty FIFO with the FSM in IDLE SHALL be popped at edge k+1; tx SHALL be 0 after edge k+1.
REQ-023 A push and a pop on the same edge SHALL leave fifo_level unchanged.
REQ-024 The same-edge push/pop case SHALL be legal at every fifo_level except FIFO_DEPTH, where s_ready=0 blocks the push.
REQ-025 tx, tx_busy and frame_done SHALL be registered outputs.

Reset
REQ-026 While rst=1, asynchronously: tx=1, tx_busy=0, frame_done=0, fifo_level=0, s_ready=0, FSM=IDLE, pointers and counters=0.
REQ-027 s_ready SHALL go to 1 on the first edge after rst deasserts.
REQ-028 Reset during a frame SHALL abort the frame immediately (tx=1) and discard all FIFO contents.

Verification (bench parameters: CLK_FREQ_HZ=40, BAUDRATE=10 so DIV=4; DATA_WIDTH=8; FIFO_DEPTH=4)
REQ-029 Single word, no parity: push 0xA5 -> tx holds 0,1,0,1,0,0,1,0,1,1, 4 cycles each; frame_done pulses once, 40 cycles after tx falls.
REQ-030 Even parity, STOP_BITS=2: push 0x07 -> parity bit 1, tx high 8 cycles at the end, frame length 48 cycles.
REQ-031 Odd parity: push 0x03 -> parity bit 1; push 0x01 -> parity bit 0.
REQ-032 Fill: push 6 words back-to-back with s_valid held at 1:
- s_ready drops when fifo_level=4;
- the remaining words are accepted as pops free space;
- all 6 are emitted in order with no idle gap;
- tx_busy stays 1 throughout.
REQ-033 Same-edge push/pop: push a word on the edge the FSM pops at fifo_level=2 -> fifo_level stays 2.
REQ-034 Mid-frame reset: assert rst during DATA bit 3 with 2 words queued -> tx=1 and fifo_level=0 immediately; no further frames after release.
